// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types and defaults for the parameterised sequence detector
package seq_det_pkg;

    localparam int DEF_DATA_W  = 3;
    localparam int DEF_SEQ_LEN = 8;
    localparam int DEF_CNT_W   = 8;

    // Element 0 (first expected element) sits in the LSBs.
    localparam logic [DEF_SEQ_LEN*DEF_DATA_W-1:0] DEF_PATTERN = {
        3'b101, 3'b011, 3'b110, 3'b110, 3'b000, 3'b110, 3'b101, 3'b001
    };

    // Detection control: FILLING until SEQ_LEN beats are held, then ARMED.
    typedef enum logic {
        FILLING = 1'b0,
        ARMED   = 1'b1
    } det_state_t;

    // Fill counter has to represent 0..seq_len inclusive.
    function automatic int fill_width(input int seq_len);
        return $clog2(seq_len + 1);
    endfunction

endpackage

// File: rtl/seq_det_history.sv
// rtl/seq_det_history.sv - history shift register of accepted elements with saturating fill counter
module seq_det_history
    import seq_det_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SEQ_LEN = DEF_SEQ_LEN,
    parameter int FILL_W  = fill_width(DEF_SEQ_LEN)
)(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      shift_en,
    input  logic                      fill_clr,
    input  logic [DATA_W-1:0]         data_in,
    output logic [SEQ_LEN*DATA_W-1:0] history,
    output logic [FILL_W-1:0]         fill
);

    localparam int                HW        = SEQ_LEN * DATA_W;
    localparam logic [FILL_W-1:0] FULL_FILL = FILL_W'(SEQ_LEN);

    // Element 0 is the oldest; new elements enter at the top and the oldest drops out the bottom.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            history <= '0;
        end else if (shift_en) begin
            history <= HW'({data_in, history} >> DATA_W);
        end
    end

    // Fill counts accepted elements up to SEQ_LEN; a clear overrides a concurrent shift.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fill <= '0;
        end else if (fill_clr) begin
            fill <= '0;
        end else if (shift_en && (fill != FULL_FILL)) begin
            fill <= fill + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parameterised stream pattern detector; optional per-element mask under SEQ_DET_MASK_EN
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                          DATA_W       = DEF_DATA_W,
    parameter int                          SEQ_LEN      = DEF_SEQ_LEN,
    parameter int                          CNT_W        = DEF_CNT_W,
    parameter logic [SEQ_LEN*DATA_W-1:0]   PATTERN_INIT = DEF_PATTERN
)(
    input  logic                       clock,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       data_valid,
    input  logic                       overlap_en,
    input  logic                       cfg_wr,
    input  logic [$clog2(SEQ_LEN)-1:0] cfg_idx,
    input  logic [DATA_W-1:0]          cfg_data,
`ifdef SEQ_DET_MASK_EN
    input  logic                       cfg_mask,
`endif
    input  logic                       clear_count,
    output logic                       sequence_found,
    output logic [CNT_W-1:0]           match_count
);

    localparam int                HW        = SEQ_LEN * DATA_W;
    localparam int                IDX_W     = $clog2(SEQ_LEN);
    localparam int                FILL_W    = fill_width(SEQ_LEN);
    localparam logic [FILL_W-1:0] LAST_FILL = FILL_W'(SEQ_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [DATA_W-1:0]  pattern_q [SEQ_LEN];
    logic [HW-1:0]      history;
    logic [FILL_W-1:0]  fill;
    logic [HW-1:0]      window;
    logic [SEQ_LEN-1:0] elem_ok;
    logic [SEQ_LEN-1:0] elem_mask;
    logic               cfg_hit;
    logic               accept;
    logic               match;
    logic               fill_clr;
    logic               armed;
    det_state_t         state;
    det_state_t         state_next;

    // An out-of-range index is treated as no write at all, so it neither clears fill nor blocks data.
    assign cfg_hit  = cfg_wr && (32'(cfg_idx) < 32'(SEQ_LEN));
    assign accept   = data_valid && !cfg_hit;
    assign fill_clr = cfg_hit || (match && !overlap_en);

    seq_det_history #(
        .DATA_W  (DATA_W),
        .SEQ_LEN (SEQ_LEN),
        .FILL_W  (FILL_W)
    ) u_history (
        .clock    (clock),
        .reset    (reset),
        .shift_en (accept),
        .fill_clr (fill_clr),
        .data_in  (data_in),
        .history  (history),
        .fill     (fill)
    );

    // Pattern elements reload from PATTERN_INIT on reset and are rewritten one at a time via cfg_wr.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < SEQ_LEN; k++) begin
                pattern_q[k] <= PATTERN_INIT[k*DATA_W +: DATA_W];
            end
        end else if (cfg_hit) begin
            pattern_q[cfg_idx] <= cfg_data;
        end
    end

`ifdef SEQ_DET_MASK_EN
    logic [SEQ_LEN-1:0] mask_q;

    // Mask bit is captured alongside the element value; a set bit makes that element a wildcard.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mask_q <= '0;
        end else if (cfg_hit) begin
            mask_q[cfg_idx] <= cfg_mask;
        end
    end

    assign elem_mask = mask_q;
`else
    assign elem_mask = '0;
`endif

    // Candidate history as it will look after this beat shifts in, compared element by element.
    assign window = HW'({data_in, history} >> DATA_W);

    always_comb begin
        elem_ok = '0;
        for (int k = 0; k < SEQ_LEN; k++) begin
            elem_ok[k] = elem_mask[k] || (window[k*DATA_W +: DATA_W] == pattern_q[k]);
        end
    end

    // The beat completes a full window if we are already armed or it is the SEQ_LEN-th element.
    assign match = accept && (armed || (fill == LAST_FILL)) && (&elem_ok);

    // Detection FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= FILLING;
        end else begin
            state <= state_next;
        end
    end

    // Detection FSM next state: arm on the last filling beat, drop back on config or a non-overlapping match.
    always_comb begin
        state_next = state;
        case (state)
            FILLING: begin
                if (accept && (fill == LAST_FILL) && !(match && !overlap_en)) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (cfg_hit || (match && !overlap_en)) begin
                    state_next = FILLING;
                end
            end
            default: state_next = FILLING;
        endcase
    end

    // Detection FSM outputs.
    always_comb begin
        armed = 1'b0;
        if (state == ARMED) begin
            armed = 1'b1;
        end
    end

    // Match pulse is registered so it appears the cycle after the completing beat.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sequence_found <= 1'b0;
        end else begin
            sequence_found <= match;
        end
    end

    // Saturating match counter; a clear coinciding with a match leaves exactly that one match counted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            match_count <= '0;
        end else if (clear_count) begin
            match_count <= match ? CNT_W'(1) : '0;
        end else if (match && (match_count != CNT_MAX)) begin
            match_count <= match_count + 1'b1;
        end
    end

endmodule
